// File: rtl/mdu_ctrl_if.sv
// Issue-side bundle between the E stage and the MDU issue controller.
// The master modport drives the E-stage request; the slave modport is the controller.
interface mdu_ctrl_if;
    logic        req;
    logic [3:0]  op;
    logic        flush;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] stall_cycles;

    // Handshake: a request is offered while req=1 and is accepted in the cycle
    // mdu_start=1; while stall=1 the E stage must hold req/op unchanged.
    modport master (
        output req, op, flush,
        input  mdu_start, mdu_op, stall, busy, done, stall_cycles
    );

    modport slave (
        input  req, op, flush,
        output mdu_start, mdu_op, stall, busy, done, stall_cycles
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU issue controller: single-cycle start pulses, mult/div occupancy tracking,
// stalling of further MDU instructions while busy, and a wrapping stall counter.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus_if,
    output logic [1:0] dbg_state_o
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic op_valid;
    logic vreq;
    logic start;
    logic stall;

    assign op_valid = (bus_if.op >= 4'd1) && (bus_if.op <= 4'd8);
    assign vreq     = bus_if.req & ~bus_if.flush & op_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q + {31'd0, stall};
        case (state_q)
            IDLE: begin
                if (start && (bus_if.op == 4'd1 || bus_if.op == 4'd2)) begin
                    state_d = MUL;
                    cnt_d   = CNT_W'(MULT_CYCLES - 1);
                end else if (start && (bus_if.op == 4'd3 || bus_if.op == 4'd4)) begin
                    state_d = DIV;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            MUL, DIV: begin
                // Flush never aborts an in-flight op: HI/LO writes are architectural.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        start = 1'b0;
        stall = 1'b0;
        bus_if.mdu_start = 1'b0;
        bus_if.mdu_op    = 4'd0;
        bus_if.stall     = 1'b0;
        bus_if.busy      = 1'b0;
        bus_if.done      = 1'b0;
        if (!reset) begin
            start            = vreq & (state_q == IDLE);
            stall            = vreq & (state_q != IDLE);
            bus_if.mdu_start = start;
            bus_if.mdu_op    = start ? bus_if.op : 4'd0;
            bus_if.stall     = stall;
            bus_if.busy      = (state_q != IDLE);
            bus_if.done      = (state_q != IDLE) && (cnt_q == '0);
        end
    end

    assign bus_if.stall_cycles = stall_cycles_q;
    assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a time-window model.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] dbg_state;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_if     (bus.slave),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model: an operation issued in cycle iss occupies cycles iss+1 .. end_c.
    int          cyc = 0;
    bit          has_op = 0;
    int          iss_c = 0;
    int          end_c = 0;
    logic [31:0] m_sc = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic in_flight, vreq, e_start, e_stall, e_busy, e_done;
            in_flight = has_op && (cyc > iss_c) && (cyc <= end_c);
            vreq = bus.req && !bus.flush && (bus.op >= 1) && (bus.op <= 8);
            if (reset) begin
                e_start = 0; e_stall = 0; e_busy = 0; e_done = 0;
            end else begin
                e_busy  = in_flight;
                e_done  = in_flight && (cyc == end_c);
                e_start = vreq && !in_flight;
                e_stall = vreq && in_flight;
            end
            cmp("mdu_start", {31'd0, bus.mdu_start}, {31'd0, e_start});
            cmp("mdu_op", {28'd0, bus.mdu_op}, e_start ? {28'd0, bus.op} : 32'd0);
            cmp("stall", {31'd0, bus.stall}, {31'd0, e_stall});
            cmp("busy", {31'd0, bus.busy}, {31'd0, e_busy});
            cmp("done", {31'd0, bus.done}, {31'd0, e_done});
            cmp("stall_cycles", bus.stall_cycles, m_sc);
            if (reset) begin
                has_op = 0;
                m_sc   = '0;
            end else begin
                if (e_stall) m_sc = m_sc + 1;
                if (e_start && bus.op >= 1 && bus.op <= 4) begin
                    has_op = 1;
                    iss_c  = cyc;
                    end_c  = cyc + ((bus.op <= 2) ? MC : DC);
                end
            end
        end
        cyc++;
    end

    task automatic drv(input logic r, input logic rq, input logic [3:0] o, input logic f);
        reset = r; bus.req = rq; bus.op = o; bus.flush = f;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        drv(1, 0, 4'd0, 0); tick();
    endtask

    initial begin
        int c;
        bit got;
        drv(1, 1, 4'd1, 0);
        tick();
        chk_en = 1;

        // Reset masks outputs even with a request present; then mult at cycle 0.
        drv(1, 1, 4'd1, 0); mid();
        cmp("lit_rst_start", {31'd0, bus.mdu_start}, 32'd0);
        cmp("lit_rst_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        drv(0, 1, 4'd1, 0); mid();
        cmp("lit_mult_start", {31'd0, bus.mdu_start}, 32'd1);
        cmp("lit_mult_op", {28'd0, bus.mdu_op}, 32'd1);
        tick();
        drv(0, 0, 4'd0, 0);
        for (int k = 1; k <= 6; k++) begin
            mid();
            cmp("lit_mult_busy", {31'd0, bus.busy}, (k <= 5) ? 32'd1 : 32'd0);
            cmp("lit_mult_done", {31'd0, bus.done}, (k == 5) ? 32'd1 : 32'd0);
            tick();
        end

        // div then mflo held until it issues.
        do_reset();
        drv(0, 1, 4'd3, 0); mid();
        cmp("lit_div_start", {31'd0, bus.mdu_start}, 32'd1);
        tick();
        drv(0, 1, 4'd6, 0);
        c = 1; got = 0;
        while (!got && c < 20) begin
            mid();
            if (bus.mdu_start) begin
                got = 1;
            end else begin
                cmp("lit_mflo_stall", {31'd0, bus.stall}, 32'd1);
                tick();
                c++;
            end
        end
        cmp("lit_mflo_timeout", {31'd0, got}, 32'd1);
        cmp("lit_mflo_cycle", c, 32'd11);
        cmp("lit_mflo_op", {28'd0, bus.mdu_op}, 32'd6);
        tick();
        drv(0, 0, 4'd0, 0); mid();
        cmp("lit_mflo_sc", bus.stall_cycles, 32'd10);
        tick();

        // mult, mthi held, flush at cycle 3 masks stall only.
        do_reset();
        drv(0, 1, 4'd1, 0); tick();
        for (int k = 1; k <= 6; k++) begin
            drv(0, 1, 4'd7, (k == 3)); mid();
            if (k < 6) begin
                cmp("lit_mthi_stall", {31'd0, bus.stall}, (k != 3) ? 32'd1 : 32'd0);
                cmp("lit_mthi_busy", {31'd0, bus.busy}, 32'd1);
            end else begin
                cmp("lit_mthi_start", {31'd0, bus.mdu_start}, 32'd1);
                cmp("lit_mthi_busy6", {31'd0, bus.busy}, 32'd0);
            end
            tick();
        end
        drv(0, 0, 4'd0, 0); mid();
        cmp("lit_mthi_sc", bus.stall_cycles, 32'd4);
        tick();

        // Invalid opcodes and flushed div in IDLE.
        do_reset();
        drv(0, 1, 4'd0, 0); mid();
        cmp("lit_op0_start", {31'd0, bus.mdu_start}, 32'd0);
        cmp("lit_op0_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        drv(0, 1, 4'd12, 0); mid();
        cmp("lit_op12_start", {31'd0, bus.mdu_start}, 32'd0);
        tick();
        drv(0, 1, 4'd3, 1); mid();
        cmp("lit_flush_start", {31'd0, bus.mdu_start}, 32'd0);
        tick();
        drv(0, 0, 4'd0, 0); mid();
        cmp("lit_flush_busy", {31'd0, bus.busy}, 32'd0);
        cmp("lit_flush_state", {30'd0, dbg_state}, 32'd0);
        tick();

        // Reset mid-div, then a clean mult.
        do_reset();
        drv(0, 1, 4'd3, 0); tick();
        drv(0, 0, 4'd0, 0);
        for (int k = 1; k <= 3; k++) begin
            mid(); cmp("lit_rdiv_busy", {31'd0, bus.busy}, 32'd1); tick();
        end
        drv(1, 1, 4'd1, 0); mid();
        cmp("lit_rdiv_rbusy", {31'd0, bus.busy}, 32'd0);
        tick();
        drv(0, 0, 4'd0, 0); mid();
        cmp("lit_rdiv_busy5", {31'd0, bus.busy}, 32'd0);
        cmp("lit_rdiv_done5", {31'd0, bus.done}, 32'd0);
        cmp("lit_rdiv_sc", bus.stall_cycles, 32'd0);
        tick();
        drv(0, 1, 4'd1, 0); mid();
        cmp("lit_rmul_start", {31'd0, bus.mdu_start}, 32'd1);
        tick();
        drv(0, 0, 4'd0, 0);
        for (int k = 7; k <= 12; k++) begin
            mid();
            cmp("lit_rmul_busy", {31'd0, bus.busy}, (k <= 11) ? 32'd1 : 32'd0);
            cmp("lit_rmul_done", {31'd0, bus.done}, (k == 11) ? 32'd1 : 32'd0);
            tick();
        end

        // stall_cycles wrap from a preloaded value.
        do_reset();
        drv(0, 1, 4'd1, 0); mid();
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        tick();
        release dut.stall_cycles_q;
        m_sc = 32'hFFFF_FFFE;
        drv(0, 1, 4'd1, 0);
        mid(); cmp("lit_wrap_fe", bus.stall_cycles, 32'hFFFF_FFFE); tick();
        mid(); cmp("lit_wrap_ff", bus.stall_cycles, 32'hFFFF_FFFF); tick();
        mid(); cmp("lit_wrap_00", bus.stall_cycles, 32'h0000_0000); tick();
        mid(); cmp("lit_wrap_01", bus.stall_cycles, 32'h0000_0001); tick();
        drv(0, 0, 4'd0, 0); tick();

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(1, 8));
            drv(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), o,
                ($urandom_range(0, 7) == 0));
            tick();
        end

        drv(0, 0, 4'd0, 0);
        tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
